// File: rtl/weight_feeder_pkg.sv
// Shared constants and FSM encoding for the first-layer weight feeder.
// A kernel set is 11 kernels x 7 weights packed into 9 words of 9 bytes.
package weight_feeder_pkg;

    localparam int WORDS_PER_SET    = 9;
    localparam int WEIGHTS_PER_WORD = 9;
    localparam int KERNELS          = 11;
    localparam int COLS             = 7;
    localparam int WORD_W           = 72;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_PRELOAD    = 3'd1,
        ST_SWAP       = 3'd2,
        ST_RUN        = 3'd3,
        ST_WAIT_FETCH = 3'd4,
        ST_DONE       = 3'd5
    } state_e;

endpackage

// File: rtl/weight_feeder_fetch_engine.sv
// Reads one 9-word kernel set from the weight SRAM, highest word first,
// and streams it into the buffer shift chain one cycle after the read data.
module weight_fetch_engine
    import weight_feeder_pkg::*;
#(
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              launch,
    input  logic [ADDR_W-1:0] start_addr,
    output logic              mem_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [WORD_W-1:0] mem_rdata,
    output logic [WORD_W-1:0] weight_o,
    output logic              en_dff,
    output logic              fetch_done
);

    logic              mem_en_q,   mem_en_d;
    logic [ADDR_W-1:0] addr_q,     addr_d;
    logic [3:0]        cnt_q,      cnt_d;
    logic              rd_valid_q, rd_valid_d;
    logic [WORD_W-1:0] weight_q,   weight_d;
    logic              en_dff_q,   en_dff_d;
    logic              done_q,     done_d;
    logic              done_now_s;

    // The last shift strobe (read pipe already empty) marks the fetch as complete.
    assign done_now_s = en_dff_q & ~rd_valid_q;
    assign fetch_done = done_q | done_now_s;

    assign mem_en   = mem_en_q;
    assign mem_addr = addr_q;
    assign weight_o = weight_q;
    assign en_dff   = en_dff_q;

    // Address down-counter, read-valid pipe and output word register.
    always_comb begin
        mem_en_d   = mem_en_q;
        addr_d     = addr_q;
        cnt_d      = cnt_q;
        rd_valid_d = mem_en_q;
        en_dff_d   = rd_valid_q;
        weight_d   = weight_q;
        done_d     = done_q;

        if (launch) begin
            mem_en_d = 1'b1;
            addr_d   = start_addr;
            cnt_d    = 4'(WORDS_PER_SET - 1);
        end else if (mem_en_q) begin
            if (cnt_q == 4'd0) begin
                mem_en_d = 1'b0;
            end else begin
                addr_d = addr_q - ADDR_W'(1);
                cnt_d  = cnt_q - 4'd1;
            end
        end else begin
            mem_en_d = 1'b0;
        end

        if (rd_valid_q) begin
            weight_d = mem_rdata;
        end else begin
            weight_d = weight_q;
        end

        if (launch) begin
            done_d = 1'b0;
        end else begin
            done_d = fetch_done;
        end
    end

    // State register for the fetch engine.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_en_q   <= 1'b0;
            addr_q     <= '0;
            cnt_q      <= 4'd0;
            rd_valid_q <= 1'b0;
            weight_q   <= '0;
            en_dff_q   <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            mem_en_q   <= mem_en_d;
            addr_q     <= addr_d;
            cnt_q      <= cnt_d;
            rd_valid_q <= rd_valid_d;
            weight_q   <= weight_d;
            en_dff_q   <= en_dff_d;
            done_q     <= done_d;
        end
    end

endmodule

// File: rtl/weight_feeder.sv
// Job sequencer for the first-layer weight buffer: preloads set 0, then
// consumes each set in 7-column passes while prefetching the next one.
module weight_feeder
    import weight_feeder_pkg::*;
#(
    parameter int ADDR_W = 12,
    parameter int SET_W  = 8,
    parameter int PASS_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [SET_W-1:0]  num_sets,
    input  logic [PASS_W-1:0] passes,
    input  logic              pix_ready,
    output logic              mem_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [WORD_W-1:0] mem_rdata,
    output logic [WORD_W-1:0] weight_o,
    output logic              en_dff,
    output logic              ud,
    output logic              en_cnt,
    output logic [SET_W-1:0]  set_idx,
    output logic              busy,
    output logic              done
);

    state_e            state_q,      state_d;
    logic [SET_W-1:0]  set_idx_q,    set_idx_d;
    logic [SET_W-1:0]  num_sets_q,   num_sets_d;
    logic [PASS_W-1:0] passes_q,     passes_d;
    logic [ADDR_W-1:0] fetch_base_q, fetch_base_d;
    logic [2:0]        col_q,        col_d;
    logic [PASS_W-1:0] pass_q,       pass_d;

    logic              launch_s;
    logic [ADDR_W-1:0] launch_addr_s;
    logic              fetch_done_s;
    logic [SET_W:0]    next_idx_s;
    logic              more_sets_s;
    logic              last_col_s;
    logic              last_pass_s;

    weight_fetch_engine #(
        .ADDR_W (ADDR_W)
    ) u_fetch (
        .clk        (clk),
        .rst_n      (rst_n),
        .launch     (launch_s),
        .start_addr (launch_addr_s),
        .mem_en     (mem_en),
        .mem_addr   (mem_addr),
        .mem_rdata  (mem_rdata),
        .weight_o   (weight_o),
        .en_dff     (en_dff),
        .fetch_done (fetch_done_s)
    );

    assign next_idx_s  = {1'b0, set_idx_q} + {{SET_W{1'b0}}, 1'b1};
    assign more_sets_s = next_idx_s < {1'b0, num_sets_q};
    assign last_col_s  = (col_q == 3'(COLS - 1));
    assign last_pass_s = (pass_q == passes_q - PASS_W'(1));

    assign ud      = (state_q == ST_SWAP);
    assign en_cnt  = (state_q == ST_RUN) & pix_ready;
    assign done    = (state_q == ST_DONE);
    assign busy    = (state_q != ST_IDLE);
    assign set_idx = set_idx_q;

    // Next-state, job-parameter latching, column/pass counting and fetch launches.
    always_comb begin
        state_d       = state_q;
        set_idx_d     = set_idx_q;
        num_sets_d    = num_sets_q;
        passes_d      = passes_q;
        fetch_base_d  = fetch_base_q;
        col_d         = col_q;
        pass_d        = pass_q;
        launch_s      = 1'b0;
        launch_addr_s = fetch_base_q + ADDR_W'(2 * WORDS_PER_SET - 1);

        case (state_q)
            ST_IDLE: begin
                // Zero sets or zero passes would never issue a valid load, so drop them.
                if (start && (num_sets != '0) && (passes != '0)) begin
                    num_sets_d    = num_sets;
                    passes_d      = passes;
                    set_idx_d     = '0;
                    fetch_base_d  = base_addr;
                    col_d         = 3'd0;
                    pass_d        = '0;
                    launch_s      = 1'b1;
                    launch_addr_s = base_addr + ADDR_W'(WORDS_PER_SET - 1);
                    state_d       = ST_PRELOAD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_PRELOAD: begin
                if (fetch_done_s) begin
                    state_d = ST_SWAP;
                end else begin
                    state_d = ST_PRELOAD;
                end
            end
            ST_SWAP: begin
                state_d = ST_RUN;
                if (more_sets_s) begin
                    launch_s     = 1'b1;
                    fetch_base_d = fetch_base_q + ADDR_W'(WORDS_PER_SET);
                end else begin
                    launch_s = 1'b0;
                end
            end
            ST_RUN: begin
                if (pix_ready) begin
                    if (last_col_s) begin
                        col_d = 3'd0;
                        if (last_pass_s) begin
                            pass_d = '0;
                            if (more_sets_s) begin
                                if (fetch_done_s) begin
                                    set_idx_d = next_idx_s[SET_W-1:0];
                                    state_d   = ST_SWAP;
                                end else begin
                                    state_d = ST_WAIT_FETCH;
                                end
                            end else begin
                                state_d = ST_DONE;
                            end
                        end else begin
                            pass_d = pass_q + PASS_W'(1);
                        end
                    end else begin
                        col_d = col_q + 3'd1;
                    end
                end else begin
                    col_d = col_q;
                end
            end
            ST_WAIT_FETCH: begin
                if (fetch_done_s) begin
                    set_idx_d = next_idx_s[SET_W-1:0];
                    state_d   = ST_SWAP;
                end else begin
                    state_d = ST_WAIT_FETCH;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Sequencer state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            set_idx_q    <= '0;
            num_sets_q   <= '0;
            passes_q     <= '0;
            fetch_base_q <= '0;
            col_q        <= 3'd0;
            pass_q       <= '0;
        end else begin
            state_q      <= state_d;
            set_idx_q    <= set_idx_d;
            num_sets_q   <= num_sets_d;
            passes_q     <= passes_d;
            fetch_base_q <= fetch_base_d;
            col_q        <= col_d;
            pass_q       <= pass_d;
        end
    end

endmodule

// File: doc/weight_feeder.md
Name: weight_feeder

Overview:
- Sequencing source for the first-layer weight buffer: drives its 72-bit weight input, shift enable, current-weight load (update) strobe and column-count enable.
- Each kernel set is 11 kernels x 7 weights, packed as 9 words of 9 x 8-bit weights; the last 4 byte slots are padding.
- Reads kernel sets from a synchronous weight SRAM, preloads the first set, and prefetches each following set while the current set is consumed.
- A set is consumed in column passes of 7 cycles each, gated by downstream ready.

Parameters:
- ADDR_W, 12, weight-SRAM word address width.
- SET_W, 8, width of the kernel-set count.
- PASS_W, 16, width of the passes-per-set count.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  one-cycle job start; ignored while busy=1
- base_addr  in  ADDR_W  SRAM address of word 0 of set 0; latched on start
- num_sets  in  SET_W  kernel sets in job, 1..2^SET_W-1; latched on start
- passes  in  PASS_W  7-cycle passes per set, >=1; latched on start
- pix_ready  in  1  downstream can accept a column this cycle
- mem_en  out  1  SRAM read enable
- mem_addr  out  ADDR_W  SRAM read address
- mem_rdata  in  72  SRAM data, valid 1 cycle after mem_en
- weight_o  out  72  word to buffer shift chain
- en_dff  out  1  shift strobe for buffer
- ud  out  1  current-weight load strobe for buffer
- en_cnt  out  1  column-count enable for buffer
- set_idx  out  SET_W  index of the set currently loaded
- busy  out  1  job active
- done  out  1  one-cycle job-complete pulse

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; fetch engine idle.
- rst_n asserted mid-job aborts the job with no done pulse. The buffer shares rst_n.
- Memory layout: set s occupies base+9s .. base+9s+8.
- Fetch order is descending, base+9s+8 down to base+9s, so that word k lands in buffer stage k+1 after 9 shifts.
- Fetch timing:
  - mem_en is high for 9 consecutive cycles F0..F8.
  - weight_o and en_dff are registered from mem_rdata, so en_dff is high in cycles F2..F10.
  - A fetch is complete after F10.
  - weight_o holds its last value when en_dff=0.
- FSM states:
  - IDLE: busy=0. On start, latch inputs, set_idx=0, launch fetch of set 0, go to PRELOAD.
  - PRELOAD: wait for fetch complete, then go to SWAP.
  - SWAP: ud=1 for exactly one cycle, then go to RUN.
    - Entering SWAP from WAIT_FETCH or RUN increments set_idx.
    - If set_idx+1 < num_sets, launch the prefetch of the next set in the cycle after ud. ud and en_dff are never high in the same cycle.
  - RUN: en_cnt = pix_ready.
    - An internal col counter 0..6 advances on en_cnt and wraps 6 -> 0; each wrap increments the pass counter.
    - On the en_cnt that completes pass passes-1 (last column): if more sets remain, go to SWAP if the prefetch is complete, else to WAIT_FETCH; if no sets remain, go to DONE.
  - WAIT_FETCH: en_cnt=0; go to SWAP when the fetch completes.
  - DONE: done=1 for one cycle, then go to IDLE. busy falls in the IDLE cycle.
- ud is only issued with col=0, keeping the buffer's internal counter aligned (it also wraps at 6).
- pix_ready low freezes col and pass. A fetch in progress continues regardless of pix_ready.
- start while busy is ignored. num_sets=0 or passes=0 is illegal; behaviour is undefined, and the bench checks that no ud is issued.
- Address arithmetic is modulo 2^ADDR_W (wraps silently).

Decomposition:
- Shared package constants: WORDS_PER_SET=9, WEIGHTS_PER_WORD=9, KERNELS=11, COLS=7, WORD_W=72; FSM state encoding.
- One sub-module, weight_fetch_engine.
  - Inputs: launch, start address.
  - Outputs: mem_en/mem_addr generation (down-counter over 9 words), 1-cycle read-valid pipe, registered weight_o/en_dff, fetch_done flag.
  - fetch_done is cleared on launch.

Test Plan:
- Preload: base=0x100, num_sets=1, passes=1, pix_ready=1.
  - Required: mem_addr 0x108..0x100 on cycles 1..9; en_dff 9 cycles; ud once, 1 cycle after the last en_dff.
  - Required: en_cnt 7 cycles, then done; a buffer model shows kernel r col c = byte (7r+c)%9 of word (7r+c)/9.
- Prefetch overlap: num_sets=3, passes=4.
  - Required: set-1 fetch (0x111..0x109) fully overlaps the RUN of set 0.
  - Required: ud pulses exactly 28 en_cnt cycles apart; set_idx 0 -> 1 -> 2; one done.
- Fetch-bound: num_sets=2, passes=1.
  - Required: WAIT_FETCH is entered; en_cnt=0 until the set-1 fetch completes; ud never coincides with en_dff.
- Backpressure: pix_ready toggles 1,0,0,1 repeating.
  - Required: exactly 7*passes en_cnt cycles per set; col wraps only on en_cnt; ud only at col=0.
- Start during busy and reset mid-fetch:
  - Second start is ignored.
  - rst_n low at F4: all outputs 0 next cycle, no done; a new start after reset runs cleanly from set 0.
- Address wrap: base=0xFFC, ADDR_W=12.
  - Required: read order 0x004, 0x003, ..., 0x000, 0xFFF..0xFFC.
